nios2_ocimem_access_arbiter: RTL and testbench

//  Shares the Nios II on-chip debug memory (single-port RAM, 1-cycle read latency) between two requesters:
//  - the sysclk-side JTAG debug command strobes (take_action_ocimem_*), fed from the debug module wrapper;
//  - the CPU's Avalon-MM debug slave.

---
 rtl/nios2_ocimem_access_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_nios2_ocimem_access_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between sysclk-side JTAG debug commands and the
// CPU's Avalon-MM debug slave, alternating grants when both sides are waiting.
module nios2_ocimem_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    JTAG_RD
  } state_t;

  typedef enum logic {
    GRANT_JTAG,
    GRANT_CPU
  } grant_t;

  state_t state;
  state_t state_next;
  grant_t last_grant;

  logic [ADDR_W-1:0] jaddr;
  logic              slot_valid;
  logic              slot_write;
  logic [ADDR_W-1:0] slot_addr;
  logic [DATA_W-1:0] slot_data;

  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_data;
  logic              cpu_req;
  logic              grant_cpu;
  logic              grant_jtag;
  logic              jtag_busy;
  logic              a_load_only;
  logic              a_read;
  logic              queue_req;
  logic              queue_write;
  logic [ADDR_W-1:0] queue_addr;
  logic              accept;
  logic              losers;
  logic              reject;
  logic              unused_jdo;

  assign jdo_addr   = jdo[17 +: ADDR_W];
  assign jdo_data   = jdo[34:3];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Round-robin choice between the CPU and the JTAG slot, made only while the RAM is free.
  always_comb begin
    cpu_req    = avs_read | avs_write;
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (!reset && state == IDLE) begin
      if (cpu_req && slot_valid) begin
        if (last_grant == GRANT_CPU) begin
          grant_jtag = 1'b1;
        end else begin
          grant_cpu = 1'b1;
        end
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (slot_valid) begin
        grant_jtag = 1'b1;
      end
    end
  end

  // Strobe decode: an address-only load always succeeds; queued commands need an empty slot
  // and no JTAG read still in flight.
  always_comb begin
    jtag_busy   = slot_valid | (state == JTAG_RD);
    a_load_only = take_action_ocimem_a & ~jdo[35];
    a_read      = take_action_ocimem_a & jdo[35];
    queue_req   = a_read
                | (take_action_ocimem_b & ~take_action_ocimem_a)
                | (take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b);
    queue_write = take_action_ocimem_b & ~take_action_ocimem_a;
    queue_addr  = take_action_ocimem_a ? jdo_addr : jaddr;
    accept      = queue_req & ~jtag_busy;
    losers      = take_action_ocimem_a ? (take_action_ocimem_b | take_no_action_ocimem_a)
                                       : (take_action_ocimem_b & take_no_action_ocimem_a);
    reject      = (queue_req & jtag_busy) | losers;
  end

  always_comb begin
    state_next      = state;
    ram_addr        = '0;
    ram_wren        = 1'b0;
    ram_wdata       = '0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            ram_addr = avs_address;
            if (avs_write) begin
              ram_wren        = 1'b1;
              ram_wdata       = avs_writedata;
              avs_waitrequest = 1'b0;
            end else begin
              state_next = CPU_RD;
            end
          end else if (grant_jtag) begin
            ram_addr = slot_addr;
            if (slot_write) begin
              ram_wren  = 1'b1;
              ram_wdata = slot_data;
            end else begin
              state_next = JTAG_RD;
            end
          end
        end
        CPU_RD: begin
          avs_readdata    = ram_rdata;
          avs_waitrequest = 1'b0;
          state_next      = IDLE;
        end
        JTAG_RD: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_JTAG;
    end else if (grant_cpu) begin
      last_grant <= GRANT_CPU;
    end else if (grant_jtag) begin
      last_grant <= GRANT_JTAG;
    end
  end

  // Accept and grant never coincide: accepting needs an empty slot, granting needs a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_write <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
    end else if (accept) begin
      slot_valid <= 1'b1;
      slot_write <= queue_write;
      slot_addr  <= queue_addr;
      slot_data  <= jdo_data;
    end else if (grant_jtag) begin
      slot_valid <= 1'b0;
    end
  end

  // An explicit address load wins over the post-increment of a grant in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      jaddr <= '0;
    end else if (a_load_only || (a_read && accept)) begin
      jaddr <= jdo_addr;
    end else if (grant_jtag) begin
      jaddr <= jaddr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg <= '0;
    end else if (state == JTAG_RD) begin
      MonDReg <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      monitor_ready <= 1'b1;
    end else if (accept) begin
      monitor_ready <= 1'b0;
    end else if ((grant_jtag && slot_write) || state == JTAG_RD) begin
      monitor_ready <= 1'b1;
    end
  end

  // A drop in the same cycle as an address load leaves the error flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      monitor_error <= 1'b0;
    end else if (reject) begin
      monitor_error <= 1'b1;
    end else if (a_load_only) begin
      monitor_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_access_arbiter.sv
// Directed bench for nios2_ocimem_access_arbiter: a transaction-level model with a golden
// memory is checked every cycle, alongside hand-computed literal expectations.
module tb_nios2_ocimem_access_arbiter;

  localparam int HOLD_NONE = 0;
  localparam int HOLD_CPU  = 1;
  localparam int HOLD_JTAG = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload;
  logic [37:0] jdo;
  logic        take_a;
  logic        take_b;
  logic        take_na;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] ram    [256];
  logic [31:0] golden [256];

  int          m_hold;
  logic [31:0] m_hold_data;
  logic [7:0]  m_jaddr;
  logic        m_slot_valid;
  logic        m_slot_write;
  logic [7:0]  m_slot_addr;
  logic [31:0] m_slot_data;
  logic        m_last_cpu;
  logic [31:0] m_mon;
  logic        m_ready;
  logic        m_err;
  logic        m_busy;
  logic        m_done;
  logic        m_inc;
  logic        m_accept;
  logic        m_cpu_wins;
  logic        e_wait;
  logic        e_wren;
  logic        e_access;
  logic        e_ret;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_rdata;

  nios2_ocimem_access_arbiter #(
    .ADDR_W(8),
    .DATA_W(32)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_a),
    .take_action_ocimem_b   (take_b),
    .take_no_action_ocimem_a(take_na),
    .avs_address            (avs_address),
    .avs_read               (avs_read),
    .avs_write              (avs_write),
    .avs_writedata          (avs_writedata),
    .avs_readdata           (avs_readdata),
    .avs_waitrequest        (avs_waitrequest),
    .ram_addr               (ram_addr),
    .ram_wren               (ram_wren),
    .ram_wdata              (ram_wdata),
    .ram_rdata              (ram_rdata),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sa, input logic sb, input logic sna, input logic [37:0] j);
    take_a  = sa;
    take_b  = sb;
    take_na = sna;
    jdo     = j;
    tick();
    take_a  = 1'b0;
    take_b  = 1'b0;
    take_na = 1'b0;
    jdo     = '0;
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (monitor_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("ready_timeout", 32'(monitor_ready), 32'd1);
  endtask

  // Single-port RAM with one-cycle registered read, preloaded with a known pattern.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= pattern(i);
      ram_rdata <= '0;
    end else begin
      if (ram_wren) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // Transaction model: who owns the RAM this cycle, what it must see, and what JTAG reports.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) golden[i] = pattern(i);
    end
    if (reset) begin
      m_hold       = HOLD_NONE;
      m_hold_data  = '0;
      m_jaddr      = '0;
      m_slot_valid = 1'b0;
      m_slot_write = 1'b0;
      m_slot_addr  = '0;
      m_slot_data  = '0;
      m_last_cpu   = 1'b0;
      m_mon        = '0;
      m_ready      = 1'b1;
      m_err        = 1'b0;
    end else begin
      checkOutput("MonDReg", MonDReg, m_mon);
      checkOutput("monitor_ready", 32'(monitor_ready), 32'(m_ready));
      checkOutput("monitor_error", 32'(monitor_error), 32'(m_err));

      e_wait   = 1'b1;
      e_wren   = 1'b0;
      e_access = 1'b0;
      e_ret    = 1'b0;
      e_addr   = '0;
      e_wdata  = '0;
      e_rdata  = '0;
      m_busy   = m_slot_valid || (m_hold == HOLD_JTAG);
      m_done   = 1'b0;
      m_inc    = 1'b0;
      m_accept = 1'b0;

      if (m_hold == HOLD_CPU) begin
        e_wait = 1'b0;
        e_ret  = 1'b1;
        e_rdata = m_hold_data;
        m_hold = HOLD_NONE;
      end else if (m_hold == HOLD_JTAG) begin
        m_mon  = m_hold_data;
        m_done = 1'b1;
        m_hold = HOLD_NONE;
      end else begin
        m_cpu_wins = (avs_read || avs_write) && (!m_slot_valid || !m_last_cpu);
        if (m_cpu_wins) begin
          e_access   = 1'b1;
          e_addr     = avs_address;
          m_last_cpu = 1'b1;
          if (avs_write) begin
            e_wren = 1'b1;
            e_wdata = avs_writedata;
            e_wait = 1'b0;
            golden[e_addr] = e_wdata;
          end else begin
            m_hold = HOLD_CPU;
            m_hold_data = golden[e_addr];
          end
        end else if (m_slot_valid) begin
          e_access     = 1'b1;
          e_addr       = m_slot_addr;
          m_last_cpu   = 1'b0;
          m_slot_valid = 1'b0;
          m_inc        = 1'b1;
          if (m_slot_write) begin
            e_wren = 1'b1;
            e_wdata = m_slot_data;
            golden[e_addr] = e_wdata;
            m_done = 1'b1;
          end else begin
            m_hold = HOLD_JTAG;
            m_hold_data = golden[e_addr];
          end
        end
      end

      checkOutput("avs_waitrequest", 32'(avs_waitrequest), 32'(e_wait));
      checkOutput("ram_wren", 32'(ram_wren), 32'(e_wren));
      if (e_access) checkOutput("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_wren) checkOutput("ram_wdata", ram_wdata, e_wdata);
      if (e_ret) checkOutput("avs_readdata", avs_readdata, e_rdata);

      if (m_inc) m_jaddr = m_jaddr + 8'd1;
      if (take_a) begin
        if (!jdo[35]) begin
          m_jaddr = jdo[24:17];
          m_err = 1'b0;
        end else if (m_busy) begin
          m_err = 1'b1;
        end else begin
          m_accept = 1'b1;
          m_jaddr = jdo[24:17];
          m_slot_write = 1'b0;
          m_slot_addr = jdo[24:17];
        end
        if (take_b || take_na) m_err = 1'b1;
      end else if (take_b) begin
        if (m_busy) begin
          m_err = 1'b1;
        end else begin
          m_accept = 1'b1;
          m_slot_write = 1'b1;
          m_slot_addr = m_jaddr;
          m_slot_data = jdo[34:3];
        end
        if (take_na) m_err = 1'b1;
      end else if (take_na) begin
        if (m_busy) begin
          m_err = 1'b1;
        end else begin
          m_accept = 1'b1;
          m_slot_write = 1'b0;
          m_slot_addr = m_jaddr;
        end
      end
      if (m_accept) begin
        m_slot_valid = 1'b1;
        m_ready = 1'b0;
      end else if (m_done) begin
        m_ready = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    preload = 1'b1;
    jdo = '0;
    take_a = 1'b0;
    take_b = 1'b0;
    take_na = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    repeat (3) tick();
    preload = 1'b0;
    tick();
    #1;
    checkOutput("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
    checkOutput("rst_ram_wren", 32'(ram_wren), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_MonDReg", MonDReg, 32'd0);
    checkOutput("rst_ready", 32'(monitor_ready), 32'd1);
    checkOutput("rst_error", 32'(monitor_error), 32'd0);
    reset = 1'b0;

    // Address load plus read at 0x10, then auto-increment read at 0x11.
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h10));
    checkOutput("t1_ready_low", 32'(monitor_ready), 32'd0);
    tick();
    tick();
    checkOutput("t1_MonDReg", MonDReg, 32'hDEADBEEF);
    checkOutput("t1_ready", 32'(monitor_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    waitReady(8);
    checkOutput("t1_next_addr", MonDReg, 32'hC0DE0011);

    // Write at 0xFF wraps the JTAG address to 0x00.
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'hFF));
    checkOutput("t2_ready_kept", 32'(monitor_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, mk_b(32'h12345678));
    waitReady(8);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    waitReady(8);
    checkOutput("t2_wrap_read", MonDReg, 32'hC0DE0000);
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'hFF));
    waitReady(8);
    checkOutput("t2_written", MonDReg, 32'h12345678);

    // Held CPU read against a JTAG read: grants alternate.
    avs_address = 8'h20;
    avs_read = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h30));
    #1;
    checkOutput("t3_cpu_wait", 32'(avs_waitrequest), 32'd0);
    checkOutput("t3_cpu_data", avs_readdata, 32'hC0DE0020);
    tick();
    tick();
    tick();
    checkOutput("t3_jtag_data", MonDReg, 32'hC0DE0030);
    checkOutput("t3_jtag_ready", 32'(monitor_ready), 32'd1);
    tick();
    checkOutput("t3_cpu_again", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_read = 1'b0;

    // JTAG write queued behind a CPU read; a second write strobe is dropped.
    avs_address = 8'h40;
    avs_read = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, mk_b(32'h11112222));
    applyStimulus(1'b0, 1'b1, 1'b0, mk_b(32'h33334444));
    avs_read = 1'b0;
    #1;
    checkOutput("t4_error_set", 32'(monitor_error), 32'd1);
    waitReady(8);
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'h31));
    checkOutput("t4_error_clear", 32'(monitor_error), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    waitReady(8);
    checkOutput("t4_first_write", MonDReg, 32'h11112222);

    // Simultaneous a and b strobes: address loads, write dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, mk_a(1'b0, 8'h50));
    checkOutput("t5_error_set", 32'(monitor_error), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    waitReady(8);
    checkOutput("t5_addr_loaded", MonDReg, 32'hC0DE0050);
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'h50));
    checkOutput("t5_error_clear", 32'(monitor_error), 32'd0);

    // CPU read and write together count as a write, then read it back.
    avs_address = 8'h60;
    avs_writedata = 32'h600DF00D;
    avs_read = 1'b1;
    avs_write = 1'b1;
    #1;
    checkOutput("t7_wr_wait", 32'(avs_waitrequest), 32'd0);
    checkOutput("t7_wr_wren", 32'(ram_wren), 32'd1);
    tick();
    avs_write = 1'b0;
    tick();
    #1;
    checkOutput("t7_rd_wait", 32'(avs_waitrequest), 32'd0);
    checkOutput("t7_rd_data", avs_readdata, 32'h600DF00D);
    tick();
    avs_read = 1'b0;

    // Reset while a JTAG read is in flight.
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h10));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_ready", 32'(monitor_ready), 32'd1);
    checkOutput("t6_MonDReg", MonDReg, 32'd0);
    checkOutput("t6_waitrequest", 32'(avs_waitrequest), 32'd1);
    checkOutput("t6_wren", 32'(ram_wren), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h60));
    waitReady(8);
    checkOutput("t6_after_reset", MonDReg, 32'h600DF00D);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
